// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: FSM states, owner encoding and default widths.
package arbiter_types;

  localparam int unsigned LINE_WIDTH_DEF = 256;
  localparam int unsigned ADDR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I,
    ARB_D,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/cache_arbiter_req_latch.sv
// Grant-time request register: op, address, write data and owner, loaded on grant.
module arb_req_latch
  import arbiter_types::*;
#(
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  nxt_read,
  input  logic                  nxt_write,
  input  logic [ADDR_WIDTH-1:0] nxt_addr,
  input  logic [LINE_WIDTH-1:0] nxt_wdata,
  input  logic                  nxt_owner,
  output logic                  q_read,
  output logic                  q_write,
  output logic [ADDR_WIDTH-1:0] q_addr,
  output logic [LINE_WIDTH-1:0] q_wdata,
  output logic                  q_owner
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_read  <= 1'b0;
      q_write <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_owner <= 1'b0;
    end else if (load) begin
      q_read  <= nxt_read;
      q_write <= nxt_write;
      q_addr  <= nxt_addr;
      q_wdata <= nxt_wdata;
      q_owner <= nxt_owner;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one memory line port between I-cache and D-cache miss paths, one transaction at a time.
// Define CACHE_ARBITER_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t state, state_nxt;
  arb_owner_t nxt_owner, lat_owner;

  logic                  d_req, i_req;
  logic                  grant_d, grant_i, load;
  logic                  nxt_read, nxt_write;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [LINE_WIDTH-1:0] nxt_wdata;
  logic                  lat_read, lat_write, lat_owner_bit;

  assign d_req = d_pmem_read | d_pmem_write;
  assign i_req = i_pmem_read;

`ifdef CACHE_ARBITER_RR_EN
  arb_owner_t last_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_I;
    end else if (load) begin
      last_owner <= nxt_owner;
    end
  end

  // A lone requester always wins; under contention the previous owner yields.
  assign grant_d = d_req && (!i_req || (last_owner == OWN_I));
`else
  assign grant_d = d_req;
`endif
  assign grant_i = i_req && !grant_d;

  assign load = (state == ARB_IDLE) && (grant_d || grant_i);

  // Write takes precedence so the memory command can never be read and write at once.
  always_comb begin
    nxt_read  = 1'b1;
    nxt_write = 1'b0;
    nxt_addr  = i_pmem_address;
    nxt_wdata = '0;
    nxt_owner = OWN_I;
    if (grant_d) begin
      nxt_read  = !d_pmem_write;
      nxt_write = d_pmem_write;
      nxt_addr  = d_pmem_address;
      nxt_wdata = d_pmem_wdata;
      nxt_owner = OWN_D;
    end
  end

  arb_req_latch #(
    .LINE_WIDTH(LINE_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_req_latch (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .nxt_read  (nxt_read),
    .nxt_write (nxt_write),
    .nxt_addr  (nxt_addr),
    .nxt_wdata (nxt_wdata),
    .nxt_owner (nxt_owner),
    .q_read    (lat_read),
    .q_write   (lat_write),
    .q_addr    (mem_address),
    .q_wdata   (mem_wdata),
    .q_owner   (lat_owner_bit)
  );

  assign lat_owner = arb_owner_t'(lat_owner_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_rdata = '0;
    case (state)
      ARB_IDLE: begin
        if (grant_d) begin
          state_nxt = ARB_D;
        end else if (grant_i) begin
          state_nxt = ARB_I;
        end
      end
      ARB_I, ARB_D: begin
        mem_read  = lat_read;
        mem_write = lat_write;
        if (lat_owner == OWN_D) begin
          d_pmem_resp  = mem_resp;
          d_pmem_rdata = mem_rdata;
        end else begin
          i_pmem_resp  = mem_resp;
          i_pmem_rdata = mem_rdata;
        end
        if (mem_resp) begin
          state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: vector table, directed corner sequences, randomized traffic vs a timeline model.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
`ifdef CACHE_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol = 0;

  logic mem_auto = 1'b1;
  int   mem_lat = 2;
  int   mem_cnt = 0;

  logic          prev_cmd = 1'b0;
  int            n_cmds = 0;
  int            cmd_cyc = 0;
  logic          cmd_rd, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_wdata;
  logic [AW-1:0] cmd_log[$];
  int            n_iresp = 0, n_dresp = 0;

  logic auto_drop = 1'b1;
  logic cont_i = 1'b0, cont_d = 1'b0;
  int   i_drop_cyc = -10, d_drop_cyc = -10;

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = a ^ (32'h5A5A_0000 + k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: memory model reacts after the edge, outputs are observed, caches react.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_auto) begin
      if (mem_resp) begin
        mem_resp = 1'b0; mem_rdata = '0; mem_cnt = 0;
      end else if (mem_read || mem_write) begin
        mem_cnt++;
        if (mem_cnt == mem_lat + 1) begin
          mem_resp = 1'b1; mem_rdata = pat(mem_address);
        end
      end else begin
        mem_cnt = 0;
      end
    end
    #1;
    if ((mem_read || mem_write) && !prev_cmd) begin
      n_cmds++; cmd_cyc = cyc; cmd_rd = mem_read; cmd_wr = mem_write;
      cmd_addr = mem_address; cmd_wdata = mem_wdata; cmd_log.push_back(mem_address);
    end
    prev_cmd = mem_read || mem_write;
    if (mem_read && mem_write) viol++;
    if (i_pmem_resp && d_pmem_resp) viol++;
    if ((i_pmem_resp || d_pmem_resp) && !mem_resp) viol++;
    if (cont_i && i_drop_cyc == cyc - 1) i_pmem_read = 1'b1;
    if (cont_d && d_drop_cyc == cyc - 1) d_pmem_read = 1'b1;
    if (i_pmem_resp) begin
      n_iresp++;
      if (auto_drop) begin i_pmem_read = 1'b0; i_drop_cyc = cyc; end
    end
    if (d_pmem_resp) begin
      n_dresp++;
      if (auto_drop) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_drop_cyc = cyc; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0; mem_cnt = 0;
    cont_i = 1'b0; cont_d = 1'b0; mem_auto = 1'b1; auto_drop = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_resp(input logic want_d, input int n0, input int budget, output logic ok);
    int k = 0;
    while (((want_d ? n_dresp : n_iresp) == n0) && k < budget) begin
      step();
      k++;
    end
    ok = ((want_d ? n_dresp : n_iresp) != n0);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL resp_timeout: no %s response within %0d cycles", want_d ? "d" : "i", budget);
    end
  endtask

  task automatic wait_cmds(input int n, input int budget);
    int k = 0;
    while (n_cmds < n && k < budget) begin
      step();
      k++;
    end
    if (n_cmds < n) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: got %0d commands, required %0d", n_cmds, n);
    end
  endtask

  typedef struct {
    logic          i_rd, d_rd, d_wr;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata;
    int            lat;
    logic          e_rd, e_wr, e_d;
    logic [AW-1:0] e_addr;
  } vec_t;

  function automatic vec_t mkv(input logic i_rd, d_rd, d_wr, input logic [AW-1:0] ia, da,
                               input logic [LW-1:0] wd, input int lat,
                               input logic e_rd, e_wr, e_d, input logic [AW-1:0] ea);
    vec_t v;
    v.i_rd = i_rd; v.d_rd = d_rd; v.d_wr = d_wr; v.i_addr = ia; v.d_addr = da;
    v.d_wdata = wd; v.lat = lat; v.e_rd = e_rd; v.e_wr = e_wr; v.e_d = e_d; v.e_addr = ea;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t          vecs[7];
    logic [LW-1:0] a5;
    logic          ok, busy, b_own_d, last_d, own_d, pi, pd, cw;
    logic [AW-1:0] ca_i, ca_d, b_addr;
    logic [LW-1:0] cwd;
    int            nb, ni, nd, c1, m, free_from, addr_ok;

    a5 = {32{8'hA5}};
    vecs[0] = mkv(1, 0, 0, 32'h40,        32'h0,   '0, 4, 1, 0, 0, 32'h40);
    vecs[1] = mkv(0, 1, 0, 32'h0,         32'h200, '0, 1, 1, 0, 1, 32'h200);
    vecs[2] = mkv(0, 0, 1, 32'h0,         32'h100, a5, 2, 0, 1, 1, 32'h100);
    vecs[3] = mkv(1, 0, 1, 32'h80,        32'h100, a5, 3, 0, 1, 1, 32'h100);
    vecs[4] = mkv(1, 1, 0, 32'h80,        32'h1E0, '0, 0, 1, 0, 1, 32'h1E0);
    vecs[5] = mkv(1, 0, 0, 32'hFFFF_FFE0, 32'h0,   '0, 3, 1, 0, 0, 32'hFFFF_FFE0);
    vecs[6] = mkv(0, 0, 1, 32'h0,         32'h0,   '1, 5, 0, 1, 1, 32'h0);

    do_reset();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_resp", {i_pmem_resp, d_pmem_resp}, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // Single-grant vectors from a fresh reset (RR last_owner starts at I, so D wins ties in both builds).
    for (int v = 0; v < 7; v++) begin
      do_reset();
      mem_lat = vecs[v].lat;
      i_pmem_read = vecs[v].i_rd; i_pmem_address = vecs[v].i_addr;
      d_pmem_read = vecs[v].d_rd; d_pmem_write = vecs[v].d_wr;
      d_pmem_address = vecs[v].d_addr; d_pmem_wdata = vecs[v].d_wdata;
      ni = n_iresp; nd = n_dresp;
      step();
      c1 = cyc;
      chk($sformatf("v%0d_mem_read", v), mem_read, vecs[v].e_rd);
      chk($sformatf("v%0d_mem_write", v), mem_write, vecs[v].e_wr);
      chk($sformatf("v%0d_mem_address", v), mem_address, vecs[v].e_addr);
      if (vecs[v].e_wr) chk($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].d_wdata);
      wait_resp(vecs[v].e_d, vecs[v].e_d ? nd : ni, 40, ok);
      if (ok) begin
        chk($sformatf("v%0d_resp_cycle", v), cyc - c1, vecs[v].lat);
        chk($sformatf("v%0d_rdata", v), vecs[v].e_d ? d_pmem_rdata : i_pmem_rdata, pat(vecs[v].e_addr));
        chk($sformatf("v%0d_other_resp", v), vecs[v].e_d ? n_iresp - ni : n_dresp - nd, 0);
      end
    end

    // Simultaneous I read + D write: D first, I command exactly three cycles after D's resp.
    do_reset();
    mem_lat = 2;
    i_pmem_read = 1'b1; i_pmem_address = 32'h80;
    d_pmem_write = 1'b1; d_pmem_address = 32'h100; d_pmem_wdata = a5;
    nb = n_cmds; ni = n_iresp; nd = n_dresp;
    step();
    chk("sim_first_write", {mem_read, mem_write}, 2'b01);
    chk("sim_first_wdata", mem_wdata, a5);
    wait_resp(1'b1, nd, 40, ok);
    m = cyc;
    wait_cmds(nb + 2, 40);
    chk("sim_second_addr", cmd_addr, 32'h80);
    chk("sim_second_latency", cmd_cyc - m, 3);
    wait_resp(1'b0, ni, 40, ok);
    if (ok) chk("sim_i_rdata", i_pmem_rdata, pat(32'h80));

    // Both requesters continuously active: grant order depends on arbitration mode.
    do_reset();
    mem_lat = 1;
    cont_i = 1'b1; cont_d = 1'b1;
    i_pmem_read = 1'b1; i_pmem_address = 32'h80;
    d_pmem_read = 1'b1; d_pmem_address = 32'h100;
    nb = n_cmds;
    wait_cmds(nb + 4, 200);
    for (int g = 0; g < 4; g++) begin
      if (nb + g < cmd_log.size())
        chk($sformatf("cont_grant%0d", g), cmd_log[nb + g],
            (RR && (g % 2 == 1)) ? 32'h80 : 32'h100);
    end
    cont_i = 1'b0; cont_d = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    for (int k = 0; k < 20; k++) step();

    // Stale-request guard: request held through its resp cycle yields exactly one command.
    do_reset();
    mem_lat = 3;
    d_pmem_read = 1'b1; d_pmem_address = 32'h240;
    nb = n_cmds; nd = n_dresp;
    for (int k = 0; k < 15; k++) step();
    chk("stale_cmd_count", n_cmds - nb, 1);
    chk("stale_resp_count", n_dresp - nd, 1);

    // Reset in ARB_D abandons the write; a stray mem_resp afterwards produces nothing.
    do_reset();
    mem_auto = 1'b0;
    d_pmem_write = 1'b1; d_pmem_address = 32'h100; d_pmem_wdata = a5;
    step();
    chk("rstmid_write_on", mem_write, 1);
    step();
    rst = 1'b1;
    step();
    chk("rstmid_cmd_dropped", {mem_read, mem_write}, 0);
    rst = 1'b0; d_pmem_write = 1'b0;
    nd = n_dresp; ni = n_iresp;
    step();
    mem_resp = 1'b1; mem_rdata = pat(32'h100);
    step();
    chk("rstmid_no_resp", {i_pmem_resp, d_pmem_resp}, 0);
    mem_resp = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h3C0;
    step();
    chk("rstmid_idle_grant", {mem_read, mem_address}, {1'b1, 32'h3C0});
    mem_auto = 1'b1; mem_cnt = 0;
    wait_resp(1'b0, ni, 40, ok);
    chk("rstmid_no_d_resp", n_dresp - nd, 0);

    // Requester changes address while granted: memory keeps the grant-time address.
    do_reset();
    mem_lat = 4;
    i_pmem_read = 1'b1; i_pmem_address = 32'h300;
    ni = n_iresp; addr_ok = 1;
    step();
    i_pmem_address = 32'h9C0;
    for (int k = 0; k < 20 && n_iresp == ni; k++) begin
      if (mem_address !== 32'h300) addr_ok = 0;
      step();
    end
    if (mem_address !== 32'h300) addr_ok = 0;
    chk("latched_address_held", addr_ok, 1);
    chk("latched_resp_seen", n_iresp - ni, 1);
    for (int k = 0; k < 4; k++) step();

    // Randomized traffic checked against a timeline model of grants and completions.
    do_reset();
    busy = 1'b0; last_d = 1'b0; free_from = cyc; b_own_d = 1'b0; b_addr = '0;
    for (int t = 0; t < 800; t++) begin
      pi = i_pmem_read; pd = d_pmem_read || d_pmem_write;
      ca_i = i_pmem_address; ca_d = d_pmem_address; cw = d_pmem_write; cwd = d_pmem_wdata;
      nb = n_cmds; ni = n_iresp; nd = n_dresp;
      if (!prev_cmd) mem_lat = $urandom_range(0, 5);
      step();
      if (!busy && (cyc - 1) >= free_from && (pi || pd)) begin
        own_d = pd && !(pi && RR && last_d);
        last_d = own_d;
        chk("rnd_grant", n_cmds - nb, 1);
        chk("rnd_addr", cmd_addr, own_d ? ca_d : ca_i);
        chk("rnd_op", {cmd_rd, cmd_wr}, (own_d && cw) ? 2'b01 : 2'b10);
        if (own_d && cw) chk("rnd_wdata", cmd_wdata, cwd);
        busy = 1'b1; b_own_d = own_d; b_addr = own_d ? ca_d : ca_i;
      end else begin
        chk("rnd_no_grant", n_cmds - nb, 0);
      end
      if (busy && mem_resp) begin
        chk("rnd_resp", {n_iresp - ni, n_dresp - nd}, b_own_d ? 64'h0_0000_0001 : 64'h1_0000_0000);
        chk("rnd_rdata", b_own_d ? d_pmem_rdata : i_pmem_rdata, pat(b_addr));
        busy = 1'b0;
        free_from = cyc + 2;
      end else begin
        chk("rnd_quiet", {n_iresp - ni, n_dresp - nd}, 0);
      end
      if (t < 760) begin
        if (!i_pmem_read && n_iresp == ni && $urandom_range(0, 2) == 0) begin
          i_pmem_read = 1'b1; i_pmem_address = $urandom & 32'hFFFF_FFE0;
        end
        if (!d_pmem_read && !d_pmem_write && n_dresp == nd && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 1) d_pmem_write = 1'b1; else d_pmem_read = 1'b1;
          d_pmem_address = $urandom & 32'hFFFF_FFE0;
          for (int k = 0; k < LW / 32; k++) d_pmem_wdata[k*32 +: 32] = $urandom;
        end
      end
    end

    chk("invariants", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
